// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA write arbiter slice.
package vga_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int CW_DEF = 9;
  localparam int AW_DEF = 15;

  localparam logic [8:0] TRANSP_COLOUR_DEF = 9'h1FF;
  localparam int         FRAME_DIV_30FPS   = 1666666;

  localparam int CH_TOWER  = 0;
  localparam int CH_CAR    = 1;
  localparam int CH_MIDDLE = 2;
  localparam int CH_LASER  = 3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input logic [2:0] last);
    return (idx == last) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Client-side bus of the VGA write arbiter: requests and packed pixel data in, grant and VGA port out.
interface vga_write_arbiter_if
  import vga_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CW   = CW_DEF,
  parameter int AW   = AW_DEF
);

  logic [N_CH-1:0]    req;
  logic [N_CH-1:0]    lock;
  logic [N_CH*CW-1:0] colour_in;
  logic [N_CH*AW-1:0] coord_in;
  logic [N_CH*AW-1:0] mem_add_in;
  logic [N_CH-1:0]    grant;
  logic [CW-1:0]      colour;
  logic [AW-1:0]      coordinates;
  logic               VGA_write_enable;
  logic [AW-1:0]      mem_add;
  logic [2:0]         owner;

  modport master (
    output req, lock, colour_in, coord_in, mem_add_in,
    input  grant, colour, coordinates, VGA_write_enable, mem_add, owner
  );

  modport slave (
    input  req, lock, colour_in, coord_in, mem_add_in,
    output grant, colour, coordinates, VGA_write_enable, mem_add, owner
  );

endinterface

// File: rtl/vga_write_arbiter_frame_tick_gen.sv
// Free-running frame divider: one-cycle frame_tick every FRAME_DIV cycles with tick_enable high.
module frame_tick_gen
  import vga_pkg::*;
#(
  parameter int FRAME_DIV = FRAME_DIV_30FPS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_enable,
  output logic frame_tick
);

  localparam int              CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count enabled cycles, wrap at the last count and pulse on the wrap.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (tick_enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = {CNT_W{1'b0}};
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
      end
    end else begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= {CNT_W{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/vga_write_arbiter.sv
// N-channel pixel-writer arbiter onto the VGA write port and map-RAM address bus.
// Optional macro TRANSPARENT_SKIP_EN: granted pixels of colour TRANSP_COLOUR are consumed without a write strobe.
module vga_write_arbiter
  import vga_pkg::*;
#(
  parameter int            N_CH          = 4,
  parameter int            CW            = CW_DEF,
  parameter int            AW            = AW_DEF,
  parameter int            ARB_MODE      = ARB_FIXED,
  parameter int            MAX_BURST     = 64,
  parameter int            FRAME_DIV     = FRAME_DIV_30FPS,
  parameter logic [CW-1:0] TRANSP_COLOUR = CW'(TRANSP_COLOUR_DEF)
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_write_arbiter_if.slave   bus,
  input  logic                 tick_enable,
  output logic                 frame_tick
);

`ifdef TRANSPARENT_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif
  localparam logic [2:0] LAST_CH   = 3'(N_CH - 1);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  arb_state_e      state_q, state_d;
  logic [2:0]      owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [7:0]      burst_q, burst_d;
  logic [2:0]      arb_start_s, arb_idx_s, gnt_idx_s;
  logic            arb_valid_s, gnt_valid_s, rearb_s;
  logic            own_req_s, own_lock_s, sel_lock_s, write_s;
  logic [CW-1:0]   colour_q, sel_colour_s;
  logic [AW-1:0]   coord_q, mem_add_q, sel_coord_s, sel_mem_s;
  logic            we_q;
  logic [N_CH-1:0] grant_s;

  // Rotating-start priority search (start 0 gives fixed priority) plus owner/winner lookups.
  always_comb begin
    arb_start_s = (ARB_MODE == ARB_RR) ? rr_ptr_q : 3'd0;
    arb_valid_s = 1'b0;
    arb_idx_s   = 3'd0;
    own_req_s   = 1'b0;
    own_lock_s  = 1'b0;
    sel_lock_s  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (!arb_valid_s && bus.req[k] && (3'(k) >= arb_start_s)) begin
        arb_valid_s = 1'b1;
        arb_idx_s   = 3'(k);
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      if (!arb_valid_s && bus.req[k]) begin
        arb_valid_s = 1'b1;
        arb_idx_s   = 3'(k);
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      if (owner_q == 3'(k)) begin
        own_req_s  = bus.req[k];
        own_lock_s = bus.lock[k];
      end
      if (arb_idx_s == 3'(k)) begin
        sel_lock_s = bus.lock[k];
      end
    end
  end

  // Lock FSM; a release re-arbitrates in the same cycle from the RR pointer (already owner+1).
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_d     = burst_q;
    gnt_valid_s = 1'b0;
    gnt_idx_s   = owner_q;
    rearb_s     = 1'b0;
    case (state_q)
      ST_LOCKED: begin
        if (own_req_s && own_lock_s && (burst_q < BURST_MAX)) begin
          gnt_valid_s = 1'b1;
          burst_d     = burst_q + 8'd1;
        end else begin
          state_d = ST_IDLE;
          burst_d = 8'd0;
          rearb_s = 1'b1;
        end
      end
      ST_IDLE: begin
        rearb_s = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        burst_d = 8'd0;
      end
    endcase
    if (rearb_s && arb_valid_s) begin
      gnt_valid_s = 1'b1;
      gnt_idx_s   = arb_idx_s;
      owner_d     = arb_idx_s;
      if (ARB_MODE == ARB_RR) begin
        rr_ptr_d = wrap_inc(arb_idx_s, LAST_CH);
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
      if (sel_lock_s) begin
        state_d = ST_LOCKED;
        burst_d = 8'd1;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      gnt_idx_s = gnt_idx_s;
    end
  end

  // One-hot grant and granted-channel data select.
  always_comb begin
    grant_s      = {N_CH{1'b0}};
    sel_colour_s = {CW{1'b0}};
    sel_coord_s  = {AW{1'b0}};
    sel_mem_s    = {AW{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      grant_s[k] = gnt_valid_s && (gnt_idx_s == 3'(k));
      if (gnt_idx_s == 3'(k)) begin
        sel_colour_s = bus.colour_in[k*CW +: CW];
        sel_coord_s  = bus.coord_in[k*AW +: AW];
        sel_mem_s    = bus.mem_add_in[k*AW +: AW];
      end
    end
    write_s = !(SKIP_EN && (sel_colour_s == TRANSP_COLOUR));
  end

  // Arbiter state and the registered VGA / map-RAM output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= 3'd0;
      rr_ptr_q  <= 3'd0;
      burst_q   <= 8'd0;
      colour_q  <= {CW{1'b0}};
      coord_q   <= {AW{1'b0}};
      mem_add_q <= {AW{1'b0}};
      we_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      we_q     <= gnt_valid_s && write_s;
      if (gnt_valid_s) begin
        coord_q   <= sel_coord_s;
        mem_add_q <= sel_mem_s;
        if (write_s) begin
          colour_q <= sel_colour_s;
        end
      end
    end
  end

  assign bus.grant            = grant_s;
  assign bus.colour           = colour_q;
  assign bus.coordinates      = coord_q;
  assign bus.VGA_write_enable = we_q;
  assign bus.mem_add          = mem_add_q;
  assign bus.owner            = owner_q;

  frame_tick_gen #(
    .FRAME_DIV(FRAME_DIV)
  ) u_frame_tick_gen (
    .clk        (clk),
    .reset      (reset),
    .tick_enable(tick_enable),
    .frame_tick (frame_tick)
  );

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench: a fixed-priority and a round-robin arbiter (MAX_BURST=3, FRAME_DIV=5) share one stimulus.
module tb_vga_write_arbiter;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_s, lock_s;
  logic [35:0] colour_in_s;
  logic [59:0] coord_in_s, mem_in_s;
  logic        tick_en_s;
  logic        ft_fix, ft_rr;
  logic        exp_we;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  vga_write_arbiter_if #(.N_CH(4), .CW(9), .AW(15)) bus_fix ();
  vga_write_arbiter_if #(.N_CH(4), .CW(9), .AW(15)) bus_rr ();

  assign bus_fix.req        = req_s;
  assign bus_fix.lock       = lock_s;
  assign bus_fix.colour_in  = colour_in_s;
  assign bus_fix.coord_in   = coord_in_s;
  assign bus_fix.mem_add_in = mem_in_s;
  assign bus_rr.req         = req_s;
  assign bus_rr.lock        = lock_s;
  assign bus_rr.colour_in   = colour_in_s;
  assign bus_rr.coord_in    = coord_in_s;
  assign bus_rr.mem_add_in  = mem_in_s;

  vga_write_arbiter #(
    .N_CH(4), .CW(9), .AW(15), .ARB_MODE(ARB_FIXED), .MAX_BURST(3), .FRAME_DIV(5)
  ) u_fix (
    .clk(clk), .reset(rst), .bus(bus_fix), .tick_enable(tick_en_s), .frame_tick(ft_fix)
  );

  vga_write_arbiter #(
    .N_CH(4), .CW(9), .AW(15), .ARB_MODE(ARB_RR), .MAX_BURST(3), .FRAME_DIV(5)
  ) u_rr (
    .clk(clk), .reset(rst), .bus(bus_rr), .tick_enable(tick_en_s), .frame_tick(ft_rr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [8:0] c, input logic [14:0] xy, input logic [14:0] ma);
    colour_in_s[ch*9 +: 9]  = c;
    coord_in_s[ch*15 +: 15] = xy;
    mem_in_s[ch*15 +: 15]   = ma;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_s     = 4'b0000;
    lock_s    = 4'b0000;
    tick_en_s = 1'b0;
    #2;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; req_s = 4'b0000; lock_s = 4'b0000; tick_en_s = 1'b0;
    colour_in_s = 36'd0; coord_in_s = 60'd0; mem_in_s = 60'd0;
    #12;
    check_eq("rst_colour", bus_fix.colour, 9'h000);
    check_eq("rst_coord", bus_fix.coordinates, 15'd0);
    check_eq("rst_we", bus_fix.VGA_write_enable, 1'b0);
    check_eq("rst_mem", bus_fix.mem_add, 15'd0);
    check_eq("rst_owner", bus_fix.owner, 3'd0);
    check_eq("rst_grant", bus_fix.grant, 4'b0000);
    check_eq("rst_tick", ft_fix, 1'b0);
    check_eq("rst_rr_we", bus_rr.VGA_write_enable, 1'b0);
    rst = 1'b0;
    tick();

    // Fixed priority: req 1010 -> ch1
    set_ch(1, 9'h0A3, 15'd100, 15'd200);
    set_ch(3, 9'h011, 15'd7, 15'd8);
    req_s = 4'b1010;
    #1;
    check_eq("fix_grant", bus_fix.grant, 4'b0010);
    check_eq("rr_grant_first", bus_rr.grant, 4'b0010);
    tick();
    check_eq("fix_colour", bus_fix.colour, 9'h0A3);
    check_eq("fix_coord", bus_fix.coordinates, 15'd100);
    check_eq("fix_mem", bus_fix.mem_add, 15'd200);
    check_eq("fix_we", bus_fix.VGA_write_enable, 1'b1);
    check_eq("fix_owner", bus_fix.owner, 3'd1);
    check_eq("fix_grant_again", bus_fix.grant, 4'b0010);
    check_eq("rr_grant_ptr", bus_rr.grant, 4'b1000);

    // No request: outputs hold, strobe drops
    do_reset();
    set_ch(0, 9'h155, 15'd5, 15'd6);
    req_s = 4'b0001;
    tick();
    check_eq("nr_colour_w", bus_fix.colour, 9'h155);
    check_eq("nr_we_w", bus_fix.VGA_write_enable, 1'b1);
    req_s = 4'b0000;
    #1;
    check_eq("nr_grant", bus_fix.grant, 4'b0000);
    check_eq("nr_rr_grant", bus_rr.grant, 4'b0000);
    tick();
    check_eq("nr_we", bus_fix.VGA_write_enable, 1'b0);
    check_eq("nr_colour_hold", bus_fix.colour, 9'h155);
    check_eq("nr_coord_hold", bus_fix.coordinates, 15'd5);
    check_eq("nr_owner_hold", bus_fix.owner, 3'd0);

    // Round-robin rotation over four requesters
    do_reset();
    for (int i = 0; i < 4; i++) set_ch(i, 9'h040 | 9'(i), 15'(10 + i), 15'(20 + i));
    req_s = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("rr_grant_rot", bus_rr.grant, 4'b0001 << i);
      check_eq("fix_grant_hold", bus_fix.grant, 4'b0001);
      tick();
      check_eq("rr_colour_rot", bus_rr.colour, 9'h040 | 9'(i));
      check_eq("rr_owner_rot", bus_rr.owner, 3'(i));
      check_eq("rr_we_rot", bus_rr.VGA_write_enable, 1'b1);
    end
    #1;
    check_eq("rr_grant_wrap", bus_rr.grant, 4'b0001);

    // Burst lock: ch2 limited to 3 grants, then ch0
    do_reset();
    set_ch(0, 9'h0C0, 15'd1, 15'd2);
    set_ch(2, 9'h0C2, 15'd3, 15'd4);
    req_s = 4'b0100; lock_s = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("bl_fix_grant", bus_fix.grant, (c < 3) ? 4'b0100 : 4'b0001);
      check_eq("bl_rr_grant", bus_rr.grant, (c < 3) ? 4'b0100 : 4'b0001);
      tick();
      req_s = 4'b0101;
      check_eq("bl_rr_owner", bus_rr.owner, (c < 3) ? 3'd2 : 3'd0);
    end
    check_eq("bl_fix_colour", bus_fix.colour, 9'h0C0);
    check_eq("bl_fix_grant5", bus_fix.grant, 4'b0001);
    check_eq("bl_rr_grant5", bus_rr.grant, 4'b0100);

    // Lock dropped after two grants: ch0 takes the same cycle
    do_reset();
    req_s = 4'b0100; lock_s = 4'b0100;
    #1;
    check_eq("ld_grant1", bus_rr.grant, 4'b0100);
    tick();
    req_s = 4'b0101;
    #1;
    check_eq("ld_grant2", bus_rr.grant, 4'b0100);
    tick();
    lock_s = 4'b0000;
    #1;
    check_eq("ld_fix_grant3", bus_fix.grant, 4'b0001);
    check_eq("ld_rr_grant3", bus_rr.grant, 4'b0001);
    tick();
    check_eq("ld_owner", bus_rr.owner, 3'd0);
    check_eq("ld_we", bus_rr.VGA_write_enable, 1'b1);

    // Frame tick every 5 enabled cycles, then a 3-cycle pause
    do_reset();
    tick_en_s = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check_eq("ft_run", ft_fix, (c % 5) == 0);
      check_eq("ft_run_rr", ft_rr, (c % 5) == 0);
    end
    tick();
    tick();
    tick_en_s = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("ft_frozen", ft_fix, 1'b0);
    end
    tick_en_s = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_eq("ft_delayed", ft_fix, c == 3);
    end
    tick_en_s = 1'b0;

    // Async reset mid-burst
    do_reset();
    set_ch(0, 9'h0E0, 15'd40, 15'd41);
    set_ch(2, 9'h0E2, 15'd30, 15'd31);
    req_s = 4'b0100; lock_s = 4'b0100;
    tick();
    req_s = 4'b0101;
    tick();
    check_eq("ar_pre_owner", bus_fix.owner, 3'd2);
    check_eq("ar_pre_grant", bus_fix.grant, 4'b0100);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_we", bus_fix.VGA_write_enable, 1'b0);
    check_eq("ar_colour", bus_fix.colour, 9'h000);
    check_eq("ar_coord", bus_fix.coordinates, 15'd0);
    check_eq("ar_mem", bus_fix.mem_add, 15'd0);
    check_eq("ar_owner", bus_fix.owner, 3'd0);
    check_eq("ar_rr_owner", bus_rr.owner, 3'd0);
    check_eq("ar_fix_grant", bus_fix.grant, 4'b0001);
    check_eq("ar_rr_grant", bus_rr.grant, 4'b0001);
    #2;
    rst = 1'b0;
    tick();
    check_eq("ar_post_colour", bus_fix.colour, 9'h0E0);
    check_eq("ar_post_we", bus_fix.VGA_write_enable, 1'b1);

    // Transparent colour on ch0
    do_reset();
    set_ch(0, 9'h1FF, 15'd9, 15'd10);
    req_s = 4'b0001;
    #1;
    check_eq("tr_grant", bus_fix.grant, 4'b0001);
    tick();
`ifdef TRANSPARENT_SKIP_EN
    exp_we = 1'b0;
`else
    exp_we = 1'b1;
`endif
    check_eq("tr_we", bus_fix.VGA_write_enable, exp_we);
    check_eq("tr_coord", bus_fix.coordinates, 15'd9);
    check_eq("tr_mem", bus_fix.mem_add, 15'd10);
    req_s = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
